alu_writeback: RTL and testbench
================================

ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 Parameter: RF_AW, default 5, register-file address width (32 registers).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  ALU result present this cycle.
REQ-005 in_ready  output  1  stage accepts a result this cycle.
REQ-006 opcode  input  6  opcode of the instruction that produced the result.
REQ-007 rdst  input  RF_AW  destination register.
REQ-008 result  input  16  ALU output {hi byte, lo byte}.
REQ-009 rf_we  output  1  register-file write enable, one write per asserted cycle.
REQ-010 rf_waddr  output  RF_AW  write address.
REQ-011 rf_wdata  output  8  write data.
REQ-012 busy  output  1  a write is in progress or pending.
REQ-013 z_flag  output  1  last written low byte was zero.
REQ-014 hi_flag  output  1  last wide result had a nonzero high byte.

Function
REQ-015 Accept = in_valid && in_ready; inputs are captured only on accept.
REQ-016 FSM states: IDLE, WR_LO, WR_HI.
REQ-017 Accept moves the FSM to WR_LO; no accept in IDLE keeps IDLE.
REQ-018 In WR_LO: rf_we=1 if the captured opcode is a writing op, rf_waddr=rdst, rf_wdata=result[7:0].
REQ-019 Writing ops: 000000, 000100-001111; opcodes 000001-000011 and 010000-111111 are accepted and consumed with rf_we=0.
REQ-020 Wide ops: 000111 (mul) and 001000 (div) transition WR_LO->WR_HI.
REQ-021 WR_HI: rf_we=1, rf_waddr=(rdst+1) mod 2^RF_AW, wrapping 31->0, rf_wdata=result[15:8].
REQ-022 Narrow op in WR_LO: next state WR_LO on a same-cycle accept, else IDLE.
REQ-023 WR_HI: next state WR_LO on a same-cycle accept, else IDLE.
REQ-024 in_ready=1 in IDLE, WR_HI, and WR_LO holding a narrow op; in_ready=0 in WR_LO holding a wide op.
REQ-025 Latency: accept in cycle N -> low write in N+1; high write in N+2 for wide ops.
REQ-026 Throughput: one narrow op per cycle; a wide op occupies two write cycles.
REQ-027 busy=1 in WR_LO and WR_HI, 0 in IDLE.
REQ-028 rf_waddr and rf_wdata are 0 whenever rf_we=0.
REQ-029 in_valid while in_ready=0 is not captured; upstream holds it until in_ready=1.

Reset
REQ-030 reset forces state IDLE and clears captured opcode/rdst/result.
REQ-031 All outputs are 0 on the cycle after reset, except in_ready=1.
REQ-032 reset overrides a simultaneous accept, and reset during WR_LO or WR_HI abandons the pending write with no further rf_we.

Configuration
REQ-033 Macro WB_FLAGS_EN enables the flag logic.
REQ-034 With WB_FLAGS_EN: on each low-byte write, z_flag <= (result[7:0]==0).
REQ-035 With WB_FLAGS_EN: on each WR_HI write, hi_flag <= (result[15:8]!=0); both flags hold otherwise and reset to 0.
REQ-036 Without WB_FLAGS_EN: z_flag and hi_flag are tied to 0 and no flag registers exist.

Verification
REQ-037 Accept add (000100), rdst=3, result=0x0042 -> next cycle rf_we=1, waddr=3, wdata=0x42; then IDLE, busy=0.
REQ-038 Accept mul (000111), rdst=31, result=0x1234 -> write 0x34@31, then 0x12@0; in_ready=0 during WR_LO.
REQ-039 Back-to-back narrow ops, opcodes 000100/000101, rdst 1/2, one per cycle -> consecutive writes 1 then 2, in_ready held 1.
REQ-040 Accept opcode 000010 -> one busy cycle with rf_we=0, waddr=0, wdata=0.
REQ-041 Accept div (001000), result=0x0300, reset asserted in WR_LO -> no WR_HI write; outputs 0, in_ready=1.
REQ-042 With WB_FLAGS_EN, mul result 0x0100 -> z_flag=1, hi_flag=1; without the macro both flags stay 0.

Source files
------------

// File: rtl/alu_writeback.sv
// ALU write-back stage: writes low result byte, then high byte for wide ops (mul/div).
// Optional macro WB_FLAGS_EN adds the z_flag / hi_flag registers.
module alu_writeback #(
  parameter int RF_AW = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       opcode,
  input  logic [RF_AW-1:0] rdst,
  input  logic [15:0]      result,
  output logic             rf_we,
  output logic [RF_AW-1:0] rf_waddr,
  output logic [7:0]       rf_wdata,
  output logic             busy,
  output logic             z_flag,
  output logic             hi_flag
);

  typedef enum logic [1:0] {IDLE = 2'd0, WR_LO = 2'd1, WR_HI = 2'd2} state_t;

  localparam logic [RF_AW-1:0] ADDR_ONE = {{(RF_AW-1){1'b0}}, 1'b1};

  function automatic logic is_writing(input logic [5:0] op);
    return (op == 6'd0) || ((op >= 6'd4) && (op <= 6'd15));
  endfunction

  function automatic logic is_wide(input logic [5:0] op);
    return (op == 6'd7) || (op == 6'd8);
  endfunction

  state_t           state_r;
  logic [5:0]       op_r;
  logic [RF_AW-1:0] rdst_r;
  logic [15:0]      res_r;
  logic             we_r;
  logic [RF_AW-1:0] waddr_r;
  logic [7:0]       wdata_r;
  logic             ready_r;
  logic             busy_r;
  logic             accept_s;
  logic             go_hi_s;

  // Handshake decode and the wide-op second-write condition
  always_comb begin
    accept_s = in_valid && ready_r;
    case (state_r)
      WR_LO:   go_hi_s = is_wide(op_r);
      default: go_hi_s = 1'b0;
    endcase
  end

  // Write-back FSM with registered handshake and register-file outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      op_r    <= 6'd0;
      rdst_r  <= '0;
      res_r   <= 16'd0;
      we_r    <= 1'b0;
      waddr_r <= '0;
      wdata_r <= 8'd0;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
    end else if (go_hi_s) begin
      // ready_r is low here, so no accept can coincide with the high write
      state_r <= WR_HI;
      we_r    <= 1'b1;
      waddr_r <= rdst_r + ADDR_ONE;
      wdata_r <= res_r[15:8];
      ready_r <= 1'b1;
      busy_r  <= 1'b1;
    end else if (accept_s) begin
      state_r <= WR_LO;
      op_r    <= opcode;
      rdst_r  <= rdst;
      res_r   <= result;
      we_r    <= is_writing(opcode);
      waddr_r <= is_writing(opcode) ? rdst : '0;
      wdata_r <= is_writing(opcode) ? result[7:0] : 8'd0;
      ready_r <= !is_wide(opcode);
      busy_r  <= 1'b1;
    end else begin
      state_r <= IDLE;
      we_r    <= 1'b0;
      waddr_r <= '0;
      wdata_r <= 8'd0;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
    end
  end

  assign in_ready = ready_r;
  assign rf_we    = we_r;
  assign rf_waddr = waddr_r;
  assign rf_wdata = wdata_r;
  assign busy     = busy_r;

`ifdef WB_FLAGS_EN
  logic z_r;
  logic hi_r;

  // Flags track the byte written in the same cycle rf_we shows it
  always_ff @(posedge clk) begin
    if (reset) begin
      z_r  <= 1'b0;
      hi_r <= 1'b0;
    end else if (go_hi_s) begin
      hi_r <= (res_r[15:8] != 8'd0);
    end else if (accept_s && is_writing(opcode)) begin
      z_r  <= (result[7:0] == 8'd0);
    end else begin
      z_r  <= z_r;
      hi_r <= hi_r;
    end
  end

  assign z_flag  = z_r;
  assign hi_flag = hi_r;
`else
  assign z_flag  = 1'b0;
  assign hi_flag = 1'b0;
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Directed self-checking bench for alu_writeback; inputs change and outputs are
// sampled on the falling edge.
module tb_alu_writeback;

`ifdef WB_FLAGS_EN
  localparam logic FL = 1'b1;
`else
  localparam logic FL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  opcode;
  logic [4:0]  rdst;
  logic [15:0] result;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [7:0]  rf_wdata;
  logic        busy;
  logic        z_flag;
  logic        hi_flag;

  int passes = 0;
  int total  = 0;

  alu_writeback #(.RF_AW(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rdst(rdst), .result(result), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy),
    .z_flag(z_flag), .hi_flag(hi_flag)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic we, input logic [4:0] a,
                         input logic [7:0] d, input logic rdy, input logic bsy);
    chk({tag, ".we"},    {15'd0, rf_we},    {15'd0, we});
    chk({tag, ".waddr"}, {11'd0, rf_waddr}, {11'd0, a});
    chk({tag, ".wdata"}, {8'd0, rf_wdata},  {8'd0, d});
    chk({tag, ".ready"}, {15'd0, in_ready}, {15'd0, rdy});
    chk({tag, ".busy"},  {15'd0, busy},     {15'd0, bsy});
  endtask

  task automatic chk_flags(input string tag, input logic z, input logic hi);
    chk({tag, ".z"},  {15'd0, z_flag},  {15'd0, z});
    chk({tag, ".hi"}, {15'd0, hi_flag}, {15'd0, hi});
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rd,
                       input logic [15:0] res);
    in_valid = v;
    opcode   = op;
    rdst     = rd;
    result   = res;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 6'd0, 5'd0, 16'd0);
    @(negedge clk);
    cyc();
    reset = 1'b0;
    cyc();
    chk_out("reset", 1'b0, 5'd0, 8'h00, 1'b1, 1'b0);
    chk_flags("reset", 1'b0, 1'b0);

    // add, rdst=3
    drive(1'b1, 6'd4, 5'd3, 16'h0042);
    cyc();
    drive(1'b0, 6'd0, 5'd0, 16'd0);
    chk_out("add_lo", 1'b1, 5'd3, 8'h42, 1'b1, 1'b1);
    chk_flags("add_lo", 1'b0, 1'b0);
    cyc();
    chk_out("add_idle", 1'b0, 5'd0, 8'h00, 1'b1, 1'b0);

    // mul at rdst=31 wraps to 0; a held request waits out WR_LO
    drive(1'b1, 6'd7, 5'd31, 16'h1234);
    cyc();
    drive(1'b1, 6'd5, 5'd9, 16'h0077);
    chk_out("mul_lo", 1'b1, 5'd31, 8'h34, 1'b0, 1'b1);
    cyc();
    chk_out("mul_hi", 1'b1, 5'd0, 8'h12, 1'b1, 1'b1);
    chk_flags("mul_hi", 1'b0, FL);
    cyc();
    drive(1'b0, 6'd0, 5'd0, 16'd0);
    chk_out("held_lo", 1'b1, 5'd9, 8'h77, 1'b1, 1'b1);
    cyc();
    chk_out("held_idle", 1'b0, 5'd0, 8'h00, 1'b1, 1'b0);

    // back-to-back narrow ops
    drive(1'b1, 6'd4, 5'd1, 16'h0011);
    cyc();
    drive(1'b1, 6'd5, 5'd2, 16'h0022);
    chk_out("b2b_1", 1'b1, 5'd1, 8'h11, 1'b1, 1'b1);
    cyc();
    drive(1'b0, 6'd0, 5'd0, 16'd0);
    chk_out("b2b_2", 1'b1, 5'd2, 8'h22, 1'b1, 1'b1);
    cyc();
    chk_out("b2b_idle", 1'b0, 5'd0, 8'h00, 1'b1, 1'b0);

    // non-writing opcodes 2 and 16, writing boundary opcodes 0 and 15
    drive(1'b1, 6'd2, 5'd7, 16'hFFFF);
    cyc();
    drive(1'b1, 6'd16, 5'd4, 16'h0055);
    chk_out("op2", 1'b0, 5'd0, 8'h00, 1'b1, 1'b1);
    cyc();
    drive(1'b1, 6'd0, 5'd6, 16'h00A5);
    chk_out("op16", 1'b0, 5'd0, 8'h00, 1'b1, 1'b1);
    cyc();
    drive(1'b1, 6'd15, 5'd8, 16'h9900);
    chk_out("op0", 1'b1, 5'd6, 8'hA5, 1'b1, 1'b1);
    cyc();
    drive(1'b0, 6'd0, 5'd0, 16'd0);
    chk_out("op15", 1'b1, 5'd8, 8'h00, 1'b1, 1'b1);
    chk_flags("op15", FL, FL);
    cyc();
    chk_out("op_idle", 1'b0, 5'd0, 8'h00, 1'b1, 1'b0);

    // div abandoned by reset in WR_LO
    drive(1'b1, 6'd8, 5'd5, 16'h0300);
    cyc();
    drive(1'b0, 6'd0, 5'd0, 16'd0);
    chk_out("div_lo", 1'b1, 5'd5, 8'h00, 1'b0, 1'b1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk_out("div_rst", 1'b0, 5'd0, 8'h00, 1'b1, 1'b0);
    chk_flags("div_rst", 1'b0, 1'b0);
    cyc();
    chk_out("div_after", 1'b0, 5'd0, 8'h00, 1'b1, 1'b0);

    // reset wins over a simultaneous accept
    drive(1'b1, 6'd4, 5'd12, 16'h00EE);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    drive(1'b0, 6'd0, 5'd0, 16'd0);
    chk_out("rst_acc", 1'b0, 5'd0, 8'h00, 1'b1, 1'b0);
    cyc();
    chk_out("rst_acc2", 1'b0, 5'd0, 8'h00, 1'b1, 1'b0);

    // flags with mul 0x0100
    drive(1'b1, 6'd7, 5'd10, 16'h0100);
    cyc();
    drive(1'b0, 6'd0, 5'd0, 16'd0);
    chk_out("flg_lo", 1'b1, 5'd10, 8'h00, 1'b0, 1'b1);
    chk_flags("flg_lo", FL, 1'b0);
    cyc();
    chk_out("flg_hi", 1'b1, 5'd11, 8'h01, 1'b1, 1'b1);
    chk_flags("flg_hi", FL, FL);
    cyc();
    chk_out("flg_idle", 1'b0, 5'd0, 8'h00, 1'b1, 1'b0);
    chk_flags("flg_idle", FL, FL);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
